// File: rtl/idu_pkg.sv
// Shared definitions for the instruction decode unit: RV32I opcodes, ALU op
// encodings, dec_ctrl bit positions, exception causes and the decoded beat
// layout carried through the skid buffer.
package idu_pkg;

    // RV32I major opcodes
    localparam logic [6:0] LUI      = 7'b0110111;
    localparam logic [6:0] AUIPC    = 7'b0010111;
    localparam logic [6:0] JAL      = 7'b1101111;
    localparam logic [6:0] JALR     = 7'b1100111;
    localparam logic [6:0] BRANCH   = 7'b1100011;
    localparam logic [6:0] LOAD     = 7'b0000011;
    localparam logic [6:0] STORE    = 7'b0100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP       = 7'b0110011;
    localparam logic [6:0] MISC_MEM = 7'b0001111;
    localparam logic [6:0] SYSTEM   = 7'b1110011;

    // ALU operation presented on dec_fn
    typedef enum logic [3:0] {
        ADD   = 4'd0,
        SUB   = 4'd1,
        SLL   = 4'd2,
        SLT   = 4'd3,
        SLTU  = 4'd4,
        XOR   = 4'd5,
        SRL   = 4'd6,
        SRA   = 4'd7,
        OR    = 4'd8,
        AND   = 4'd9,
        PASSB = 4'd10
    } alu_fn_e;

    // dec_ctrl bit positions
    localparam int unsigned CTRL_RF_WE     = 0;
    localparam int unsigned CTRL_MEM_RD    = 1;
    localparam int unsigned CTRL_MEM_WR    = 2;
    localparam int unsigned CTRL_BRANCH    = 3;
    localparam int unsigned CTRL_JAL       = 4;
    localparam int unsigned CTRL_JALR      = 5;
    localparam int unsigned CTRL_SRC_A_PC  = 6;
    localparam int unsigned CTRL_SRC_B_IMM = 7;

    // Exception cause carried with a beat
    typedef enum logic [1:0] {
        CAUSE_NONE           = 2'b00,
        CAUSE_FETCH_MISALIGN = 2'b01,
        CAUSE_ILLEGAL        = 2'b10
    } cause_e;

    // Occupancy of the main/skid pair
    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_TWO
    } skid_state_e;

    // Everything the decoder derives from one instruction word
    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [31:0] imm;
        alu_fn_e     fn;
        logic [7:0]  ctrl;
        logic        exc;
        cause_e      cause;
    } dec_fields_t;

    // One stored decode beat
    typedef struct packed {
        logic [31:0] pc;
        dec_fields_t f;
    } dec_beat_t;

    // OP/OP-IMM funct3 to ALU op; alt is instr[30] already qualified by the caller
    function automatic alu_fn_e alu_from_funct3(input logic [2:0] funct3,
                                                input logic       sub_sel,
                                                input logic       sra_sel);
        alu_fn_e fn;
        case (funct3)
            3'b000:  fn = sub_sel ? SUB : ADD;
            3'b001:  fn = SLL;
            3'b010:  fn = SLT;
            3'b011:  fn = SLTU;
            3'b100:  fn = XOR;
            3'b101:  fn = sra_sel ? SRA : SRL;
            3'b110:  fn = OR;
            default: fn = AND;
        endcase
        return fn;
    endfunction

endpackage

// File: rtl/idu_if.sv
// Fetch-side and execute-side handshake/bus signals of the decode unit.
// slave is the decode unit's view, master is the surrounding pipeline's view.
interface idu_if;

    // fetch side
    logic        instr_valid;
    logic [31:0] instruction;
    logic [31:0] pc_to_EXE;
    logic        addr_unaligned;
    logic        EXE_ready;
    logic        EXE_flush;
    logic        INT_flush;

    // execute side
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_pc;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [4:0]  dec_rd;
    logic [2:0]  dec_funct3;
    logic [31:0] dec_imm;
    logic [3:0]  dec_fn;
    logic [7:0]  dec_ctrl;
    logic        dec_exc;
    logic [1:0]  dec_cause;

    modport slave (
        input  instr_valid, instruction, pc_to_EXE, addr_unaligned,
               EXE_flush, INT_flush, dec_ready,
        output EXE_ready, dec_valid, dec_pc, dec_rs1, dec_rs2, dec_rd,
               dec_funct3, dec_imm, dec_fn, dec_ctrl, dec_exc, dec_cause
    );

    modport master (
        output instr_valid, instruction, pc_to_EXE, addr_unaligned,
               EXE_flush, INT_flush, dec_ready,
        input  EXE_ready, dec_valid, dec_pc, dec_rs1, dec_rs2, dec_rd,
               dec_funct3, dec_imm, dec_fn, dec_ctrl, dec_exc, dec_cause
    );

endinterface

// File: rtl/idu_decoder.sv
// Combinational RV32I decoder: register fields, immediate, ALU op, control
// bits and exception cause for one instruction word.
// Optional: IDU_ILLEGAL_CHK_EN enables illegal-instruction detection (cause 10).
module idu_decoder
    import idu_pkg::*;
(
    input  logic [31:0] instruction,
    input  logic        addr_unaligned,
    output dec_fields_t fields
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        illegal;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    assign opcode = instruction[6:0];
    assign funct3 = instruction[14:12];

    assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
    assign imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
    assign imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                    instruction[30:25], instruction[11:8], 1'b0};
    assign imm_u = {instruction[31:12], 12'b0};
    assign imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                    instruction[20], instruction[30:21], 1'b0};

`ifdef IDU_ILLEGAL_CHK_EN
    logic [6:0] funct7;
    assign funct7 = instruction[31:25];

    // Flag opcodes outside RV32I and funct7 encodings the ALU mapping cannot honour
    always_comb begin
        illegal = 1'b0;
        case (opcode)
            LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, MISC_MEM, SYSTEM: illegal = 1'b0;
            OP_IMM: begin
                if ((funct3 == 3'b001 || funct3 == 3'b101) &&
                    funct7 != 7'h00 && funct7 != 7'h20)
                    illegal = 1'b1;
            end
            OP: begin
                if (!(funct7 == 7'h00 ||
                      (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101))))
                    illegal = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end
`else
    assign illegal = 1'b0;
`endif

    // Per-opcode immediate, ALU op and control, then exception masking
    always_comb begin
        fields        = '0;
        fields.rs1    = instruction[19:15];
        fields.rs2    = instruction[24:20];
        fields.rd     = instruction[11:7];
        fields.funct3 = funct3;
        fields.fn     = ADD;

        case (opcode)
            LUI: begin
                fields.imm                  = imm_u;
                fields.fn                   = PASSB;
                fields.ctrl[CTRL_RF_WE]     = 1'b1;
                fields.ctrl[CTRL_SRC_B_IMM] = 1'b1;
            end
            AUIPC: begin
                fields.imm                  = imm_u;
                fields.ctrl[CTRL_RF_WE]     = 1'b1;
                fields.ctrl[CTRL_SRC_A_PC]  = 1'b1;
                fields.ctrl[CTRL_SRC_B_IMM] = 1'b1;
            end
            JAL: begin
                fields.imm                  = imm_j;
                fields.ctrl[CTRL_RF_WE]     = 1'b1;
                fields.ctrl[CTRL_JAL]       = 1'b1;
                fields.ctrl[CTRL_SRC_A_PC]  = 1'b1;
                fields.ctrl[CTRL_SRC_B_IMM] = 1'b1;
            end
            JALR: begin
                fields.imm                  = imm_i;
                fields.ctrl[CTRL_RF_WE]     = 1'b1;
                fields.ctrl[CTRL_JALR]      = 1'b1;
                fields.ctrl[CTRL_SRC_B_IMM] = 1'b1;
            end
            BRANCH: begin
                fields.imm               = imm_b;
                fields.fn                = SUB;
                fields.ctrl[CTRL_BRANCH] = 1'b1;
            end
            LOAD: begin
                fields.imm                  = imm_i;
                fields.ctrl[CTRL_RF_WE]     = 1'b1;
                fields.ctrl[CTRL_MEM_RD]    = 1'b1;
                fields.ctrl[CTRL_SRC_B_IMM] = 1'b1;
            end
            STORE: begin
                fields.imm                  = imm_s;
                fields.ctrl[CTRL_MEM_WR]    = 1'b1;
                fields.ctrl[CTRL_SRC_B_IMM] = 1'b1;
            end
            OP_IMM: begin
                fields.imm                  = imm_i;
                fields.fn                   = alu_from_funct3(funct3, 1'b0, instruction[30]);
                fields.ctrl[CTRL_RF_WE]     = 1'b1;
                fields.ctrl[CTRL_SRC_B_IMM] = 1'b1;
            end
            OP: begin
                fields.fn               = alu_from_funct3(funct3, instruction[30], instruction[30]);
                fields.ctrl[CTRL_RF_WE] = 1'b1;
            end
            MISC_MEM, SYSTEM: begin
                fields.imm = imm_i;
            end
            default: begin
                fields.imm = '0;
            end
        endcase

        fields.exc = addr_unaligned || illegal;
        if (addr_unaligned)
            fields.cause = CAUSE_FETCH_MISALIGN;
        else if (illegal)
            fields.cause = CAUSE_ILLEGAL;
        else
            fields.cause = CAUSE_NONE;

        // an excepting beat must not write state or redirect the pipeline
        if (fields.exc) begin
            fields.ctrl[CTRL_RF_WE]  = 1'b0;
            fields.ctrl[CTRL_MEM_RD] = 1'b0;
            fields.ctrl[CTRL_MEM_WR] = 1'b0;
            fields.ctrl[CTRL_BRANCH] = 1'b0;
            fields.ctrl[CTRL_JAL]    = 1'b0;
            fields.ctrl[CTRL_JALR]   = 1'b0;
        end
    end

endmodule

// File: rtl/idu.sv
// Instruction decode unit: decodes the fetch beat combinationally and holds
// results in a main/skid register pair so that EXE_ready is a flop output.
// Optional: IDU_ILLEGAL_CHK_EN (see idu_decoder) enables illegal detection.
module idu
    import idu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic clk,
    input  logic rst,
    idu_if.slave bus
);

    dec_fields_t     fields;
    dec_beat_t       beat_in;
    dec_beat_t       main_q;
    dec_beat_t       skid_q;
    skid_state_e     state;
    logic            valid_q;
    logic            ready_q;
    logic            accept;
    logic            flush;
    logic [XLEN-1:0] pc_in;

    assign pc_in  = bus.pc_to_EXE;
    assign accept = bus.instr_valid && ready_q;
    assign flush  = bus.EXE_flush || bus.INT_flush;

    idu_decoder u_decoder (
        .instruction    (bus.instruction),
        .addr_unaligned (bus.addr_unaligned),
        .fields         (fields)
    );

    // Assemble the beat that would be captured on acceptance
    always_comb begin
        beat_in    = '0;
        beat_in.pc = 32'(pc_in);
        beat_in.f  = fields;
    end

    // Skid FSM: EXE_ready is registered as the next-state "skid empty"
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_EMPTY;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            main_q  <= '0;
            skid_q  <= '0;
        end else if (flush) begin
            state   <= ST_EMPTY;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        main_q  <= beat_in;
                        valid_q <= 1'b1;
                        state   <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && bus.dec_ready) begin
                        main_q <= beat_in;
                    end else if (accept) begin
                        skid_q  <= beat_in;
                        ready_q <= 1'b0;
                        state   <= ST_TWO;
                    end else if (bus.dec_ready) begin
                        valid_q <= 1'b0;
                        state   <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (bus.dec_ready) begin
                        main_q  <= skid_q;
                        ready_q <= 1'b1;
                        state   <= ST_ONE;
                    end
                end
                default: begin
                    state   <= ST_EMPTY;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.EXE_ready  = ready_q;
    assign bus.dec_valid  = valid_q;
    assign bus.dec_pc     = main_q.pc;
    assign bus.dec_rs1    = main_q.f.rs1;
    assign bus.dec_rs2    = main_q.f.rs2;
    assign bus.dec_rd     = main_q.f.rd;
    assign bus.dec_funct3 = main_q.f.funct3;
    assign bus.dec_imm    = main_q.f.imm;
    assign bus.dec_fn     = main_q.f.fn;
    assign bus.dec_ctrl   = main_q.f.ctrl;
    assign bus.dec_exc    = main_q.f.exc;
    assign bus.dec_cause  = main_q.f.cause;

endmodule

// File: tb/tb_idu.sv
// Self-checking bench for idu: a 2-deep queue model of the decode stage with
// an arithmetic reference decoder, compared every cycle, plus literal checks.
module tb_idu;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    idu_if bus();

    idu #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef IDU_ILLEGAL_CHK_EN
    localparam bit ILL_CHK = 1'b1;
`else
    localparam bit ILL_CHK = 1'b0;
`endif

    localparam logic [7:0] C_RF = 8'h01, C_MR = 8'h02, C_MW = 8'h04, C_BR = 8'h08;
    localparam logic [7:0] C_JAL = 8'h10, C_JALR = 8'h20, C_APC = 8'h40, C_BI = 8'h80;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f3;
        logic [31:0] imm;
        logic [3:0]  fn;
        logic [7:0]  ctrl;
        logic        exc;
        logic [1:0]  cause;
    } exp_t;

    int checks = 0;
    int errors = 0;
    exp_t mq[$];
    bit m_ready = 1'b1;
    bit go = 1'b0;
    logic [31:0] delivered[$];
    int F3FN [8] = '{0, 2, 3, 4, 5, 6, 8, 9};

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Reference decode from the ISA rules, using plain arithmetic for immediates
    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc, input logic ua);
        exp_t e;
        logic [6:0] op, f7;
        logic [2:0] f3;
        logic [31:0] iimm;
        bit known, bad, ill;
        op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
        iimm = 32'($signed(ins) >>> 20);
        e.pc = pc; e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7]; e.f3 = f3;
        e.imm = 0; e.fn = 0; e.ctrl = 0; known = 1; bad = 0;
        case (op)
            7'h37: begin e.imm = ins & 32'hFFFFF000; e.fn = 10; e.ctrl = C_RF | C_BI; end
            7'h17: begin e.imm = ins & 32'hFFFFF000; e.ctrl = C_RF | C_APC | C_BI; end
            7'h6F: begin
                e.imm = 32'((ins[31] ? -(1 << 20) : 0) + (int'(ins[19:12]) << 12)
                            + (int'(ins[20]) << 11) + (int'(ins[30:21]) << 1));
                e.ctrl = C_RF | C_JAL | C_APC | C_BI;
            end
            7'h67: begin e.imm = iimm; e.ctrl = C_RF | C_JALR | C_BI; end
            7'h63: begin
                e.imm = 32'((ins[31] ? -4096 : 0) + int'(ins[7]) * 2048
                            + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2);
                e.fn = 1; e.ctrl = C_BR;
            end
            7'h03: begin e.imm = iimm; e.ctrl = C_RF | C_MR | C_BI; end
            7'h23: begin e.imm = (iimm & ~32'h1F) | 32'(ins[11:7]); e.ctrl = C_MW | C_BI; end
            7'h13: begin
                e.imm = iimm; e.fn = 4'(F3FN[f3]);
                if (f3 == 5 && ins[30]) e.fn = 7;
                e.ctrl = C_RF | C_BI;
                bad = (f3 == 1 || f3 == 5) && !(f7 == 7'h00 || f7 == 7'h20);
            end
            7'h33: begin
                e.fn = 4'(F3FN[f3]);
                if (ins[30] && f3 == 0) e.fn = 1;
                if (ins[30] && f3 == 5) e.fn = 7;
                e.ctrl = C_RF;
                bad = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)));
            end
            7'h0F, 7'h73: e.imm = iimm;
            default: known = 0;
        endcase
        ill = ILL_CHK && (!known || bad);
        e.exc = ua || ill;
        e.cause = ua ? 2'd1 : (ill ? 2'd2 : 2'd0);
        if (e.exc) e.ctrl = e.ctrl & 8'hC0;
        return e;
    endfunction

    // Model: the stage behaves as a 2-deep FIFO whose "not full" is registered
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_ready = 1'b1;
        end else if (bus.EXE_flush || bus.INT_flush) begin
            mq.delete();
            m_ready = 1'b1;
        end else begin
            bit acc;
            acc = bus.instr_valid && m_ready;
            if (bus.dec_ready && mq.size() != 0) void'(mq.pop_front());
            if (acc) mq.push_back(ref_decode(bus.instruction, bus.pc_to_EXE, bus.addr_unaligned));
            m_ready = (mq.size() < 2);
        end
    end

    // Compare DUT against the model every cycle
    always @(negedge clk) begin
        exp_t e;
        if (go) begin
            chk("dec_valid", 32'(bus.dec_valid), 32'(mq.size() != 0));
            chk("EXE_ready", 32'(bus.EXE_ready), 32'(m_ready));
            if (mq.size() != 0) begin
                e = mq[0];
                chk("dec_pc", bus.dec_pc, e.pc);
                chk("dec_rs1", 32'(bus.dec_rs1), 32'(e.rs1));
                chk("dec_rs2", 32'(bus.dec_rs2), 32'(e.rs2));
                chk("dec_rd", 32'(bus.dec_rd), 32'(e.rd));
                chk("dec_funct3", 32'(bus.dec_funct3), 32'(e.f3));
                chk("dec_imm", bus.dec_imm, e.imm);
                chk("dec_fn", 32'(bus.dec_fn), 32'(e.fn));
                chk("dec_ctrl", 32'(bus.dec_ctrl), 32'(e.ctrl));
                chk("dec_exc", 32'(bus.dec_exc), 32'(e.exc));
                chk("dec_cause", 32'(bus.dec_cause), 32'(e.cause));
            end
            if (bus.dec_valid && bus.dec_ready && !rst) delivered.push_back(bus.dec_pc);
        end
    end

    task automatic send(input logic [31:0] ins, input logic [31:0] pc, input logic ua);
        bit r;
        int n;
        bus.instr_valid = 1'b1; bus.instruction = ins; bus.pc_to_EXE = pc; bus.addr_unaligned = ua;
        n = 0;
        do begin
            r = bus.EXE_ready;
            @(posedge clk); #1;
            n++;
        end while (!r && n < 20);
        chk("send_accepted", 32'(r), 32'd1);
        bus.instr_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.instr_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_list[$];
        bus.instr_valid = 0; bus.instruction = 0; bus.pc_to_EXE = 0; bus.addr_unaligned = 0;
        bus.EXE_flush = 0; bus.INT_flush = 0; bus.dec_ready = 0;

        // reset
        @(posedge clk); #1;
        go = 1'b1;
        chk("rst_valid", 32'(bus.dec_valid), 0);
        chk("rst_ready", 32'(bus.EXE_ready), 1);
        chk("rst_imm", bus.dec_imm, 0);
        chk("rst_ctrl", 32'(bus.dec_ctrl), 0);
        chk("rst_pc", bus.dec_pc, 0);
        chk("rst_cause", 32'(bus.dec_cause), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // ADDI x1,x0,5
        bus.dec_ready = 1'b1;
        send(32'h00500093, 32'h80, 0);
        chk("addi_valid", 32'(bus.dec_valid), 1);
        chk("addi_pc", bus.dec_pc, 32'h80);
        chk("addi_rd", 32'(bus.dec_rd), 1);
        chk("addi_rs1", 32'(bus.dec_rs1), 0);
        chk("addi_imm", bus.dec_imm, 5);
        chk("addi_fn", 32'(bus.dec_fn), 0);
        chk("addi_ctrl", 32'(bus.dec_ctrl), 32'h81);

        // BEQ x1,x2,-8
        send(32'hFE208CE3, 32'h84, 0);
        chk("beq_rs1", 32'(bus.dec_rs1), 1);
        chk("beq_rs2", 32'(bus.dec_rs2), 2);
        chk("beq_imm", bus.dec_imm, 32'hFFFFFFF8);
        chk("beq_fn", 32'(bus.dec_fn), 1);
        chk("beq_ctrl", 32'(bus.dec_ctrl), 32'h08);
        chk("beq_funct3", 32'(bus.dec_funct3), 0);
        idle(1);

        // backpressure: A, B fill both entries, C waits
        bus.dec_ready = 1'b0;
        send(32'h002081B3, 32'h100, 0);
        send(32'h40208233, 32'h104, 0);
        chk("bp_ready_low", 32'(bus.EXE_ready), 0);
        bus.instr_valid = 1'b1; bus.instruction = 32'h123452B7; bus.pc_to_EXE = 32'h108;
        repeat (2) begin @(posedge clk); #1; end
        chk("bp_hold_pc", bus.dec_pc, 32'h100);
        chk("bp_hold_ready", 32'(bus.EXE_ready), 0);
        bus.dec_ready = 1'b1;
        send(32'h123452B7, 32'h108, 0);
        chk("bp_c_pc", bus.dec_pc, 32'h108);
        idle(1);

        // back-to-back burst at full throughput
        send(32'h0080A183, 32'h500, 0);
        send(32'h0020A623, 32'h504, 0);
        chk("sw_imm", bus.dec_imm, 12);
        chk("sw_ctrl", 32'(bus.dec_ctrl), 32'h84);
        send(32'h010000EF, 32'h508, 0);
        chk("jal_imm", bus.dec_imm, 16);
        chk("jal_ctrl", 32'(bus.dec_ctrl), 32'hD1);
        send(32'h4030D093, 32'h50C, 0);
        chk("srai_fn", 32'(bus.dec_fn), 7);
        chk("srai_imm", bus.dec_imm, 32'h403);
        send(32'h123452B7, 32'h510, 0);
        send(32'h00001517, 32'h514, 0);
        send(32'h000080E7, 32'h518, 0);
        send(32'h0020B1B3, 32'h51C, 0);
        idle(1);

        // INT_flush while full, with a beat offered
        bus.dec_ready = 1'b0;
        send(32'h00100093, 32'h600, 0);
        send(32'h00200093, 32'h604, 0);
        bus.INT_flush = 1'b1;
        bus.instr_valid = 1'b1; bus.instruction = 32'h00300093; bus.pc_to_EXE = 32'h608;
        @(posedge clk); #1;
        bus.INT_flush = 1'b0; bus.instr_valid = 1'b0;
        chk("int_flush_valid", 32'(bus.dec_valid), 0);
        chk("int_flush_ready", 32'(bus.EXE_ready), 1);
        bus.dec_ready = 1'b1;
        idle(3);

        // EXE_flush in ONE: consumed beat delivered, accepted beat dropped
        bus.dec_ready = 1'b0;
        send(32'h00400093, 32'h700, 0);
        bus.dec_ready = 1'b1; bus.EXE_flush = 1'b1;
        bus.instr_valid = 1'b1; bus.instruction = 32'h00500093; bus.pc_to_EXE = 32'h704;
        @(posedge clk); #1;
        bus.EXE_flush = 1'b0; bus.instr_valid = 1'b0;
        chk("exe_flush_valid", 32'(bus.dec_valid), 0);
        idle(2);

        // faults
        send(32'hFFFFFFFF, 32'h800, 0);
        chk("ill_exc", 32'(bus.dec_exc), 32'(ILL_CHK));
        chk("ill_cause", 32'(bus.dec_cause), ILL_CHK ? 32'd2 : 32'd0);
        chk("ill_ctrl", 32'(bus.dec_ctrl), 0);
        send(32'hFFFFFFFF, 32'h804, 1);
        chk("ua_ill_exc", 32'(bus.dec_exc), 1);
        chk("ua_ill_cause", 32'(bus.dec_cause), 1);
        chk("ua_ill_ctrl", 32'(bus.dec_ctrl), 0);
        send(32'h00500093, 32'h808, 1);
        chk("ua_addi_ctrl", 32'(bus.dec_ctrl), 32'h80);
        chk("ua_addi_pc", bus.dec_pc, 32'h808);
        idle(1);

        // asynchronous reset while full
        bus.dec_ready = 1'b0;
        send(32'h00100093, 32'h900, 0);
        send(32'h00200093, 32'h904, 0);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(bus.dec_valid), 0);
        chk("async_rst_ready", 32'(bus.EXE_ready), 1);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.dec_ready = 1'b1;
        send(32'h00500093, 32'h910, 0);
        chk("post_rst_pc", bus.dec_pc, 32'h910);
        idle(1);

        // every delivered beat exactly once, in order, none of the flushed ones
        exp_list = '{32'h80, 32'h84, 32'h100, 32'h104, 32'h108,
                     32'h500, 32'h504, 32'h508, 32'h50C, 32'h510, 32'h514, 32'h518, 32'h51C,
                     32'h700, 32'h800, 32'h804, 32'h808, 32'h910};
        chk("delivered_count", 32'(delivered.size()), 32'(exp_list.size()));
        for (int i = 0; i < exp_list.size(); i++)
            chk("delivered_pc", (i < delivered.size()) ? delivered[i] : 32'hDEADBEEF, exp_list[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/idu.md
# idu

Instruction decode unit, sitting directly downstream of the fetch unit. It accepts one fetched instruction per cycle over the fetch valid/ready handshake, decodes RV32I fields, immediates and control, and registers the result. A two-entry skid buffer holds the result so that the ready signal returned to fetch is a pure flop output. The registered decode beat is presented to the execute stage over its own valid/ready handshake, and the unit honours execute and interrupt flushes.

## Interface
Parameters:
- `XLEN`, default 32: data and PC width. Only 32 is supported.

Ports:
- `clk` in 1: clock.
- `rst` in 1: asynchronous reset, active-high.
- `instr_valid` in 1: a fetched instruction is present on the fetch side.
- `instruction` in 32: fetched instruction word.
- `pc_to_EXE` in 32: PC of `instruction`.
- `addr_unaligned` in 1: fetch misalignment fault for this beat.
- `EXE_ready` out 1: idu can accept a beat. Registered.
- `EXE_flush` in 1: branch/jump flush.
- `INT_flush` in 1: interrupt/exception flush.
- `dec_valid` out 1: decoded beat valid.
- `dec_ready` in 1: execute consumes the beat.
- `dec_pc` out 32: PC of the decoded beat.
- `dec_rs1`, `dec_rs2`, `dec_rd` out 5 each: register indices.
- `dec_funct3` out 3: `instruction[14:12]`.
- `dec_imm` out 32: sign-extended immediate (I/S/B/U/J format; 0 for R-type).
- `dec_fn` out 4: ALU op per `idu_pkg`.
- `dec_ctrl` out 8: control bits:
  - [0] `rf_we`
  - [1] `mem_rd`
  - [2] `mem_wr`
  - [3] `branch`
  - [4] `jal`
  - [5] `jalr`
  - [6] `src_a_pc`
  - [7] `src_b_imm`
- `dec_exc` out 1: beat carries an exception.
- `dec_cause` out 2: `00` none, `01` fetch misaligned, `10` illegal instruction.

## Operation
- **Decode is combinational.** It is computed on the fetch-side inputs and captured only on acceptance.
- **Acceptance:** `instr_valid && EXE_ready`.
- **Storage:**
  - `main` register drives the `dec_*` outputs.
  - `skid` register holds the overflow entry.
- **States:** EMPTY (neither valid), ONE (`main` valid), TWO (both valid).
  - EMPTY: accept → ONE, loads `main`.
  - ONE: accept with `dec_ready` → ONE, `main` reloaded. Accept without `dec_ready` → TWO, loads `skid`. `dec_ready` with no accept → EMPTY.
  - TWO: `dec_ready` → ONE, `skid` moves to `main`. No acceptance is possible in TWO.
- **Ready to fetch:** `EXE_ready` is the next-state value `!skid_valid`, registered.
- **Flush:** `EXE_flush || INT_flush` has highest priority.
  - Both valids clear at the next edge.
  - A beat accepted in the flush cycle is dropped.
  - A beat consumed in the flush cycle counts as delivered.
- **ALU op mapping:**
  - `LUI` → `PASSB`.
  - `AUIPC`, loads, stores, `JAL`, `JALR` → `ADD`.
  - Branches → `SUB`.
  - OP / OP-IMM → per `funct3` and `instr[30]`. `instr[30]` selects `SUB` for OP only and `SRA` for both OP and OP-IMM.
- **Exception beats:**
  - `dec_exc=1` forces `rf_we=0`, `mem_rd=0`, `mem_wr=0`, `branch=0`, `jal=0`, `jalr=0`.
  - `dec_pc` is kept.
  - If both faults are present, `addr_unaligned` wins over illegal.
- **No-writeback instructions:** stores and branches report the `rd` field but `rf_we=0`. An instruction with `rd=x0` keeps `rf_we=1` as decoded; the register file ignores x0.

## Timing
- **Latency:** a beat accepted at edge N is visible on `dec_*` after edge N.
- **Throughput:** one beat per cycle while `dec_ready` is held high.
- **Reset values:**
  - `dec_valid=0`, `EXE_ready=1`.
  - All `dec_*` data, `dec_ctrl`, `dec_exc` and `dec_cause` are 0.
- **Backpressure:** `EXE_ready` falls the cycle after the skid fills. It returns to 1 the cycle after `skid` drains into `main`, or after a flush.
- **Output stability:** `dec_*` outputs are stable while `dec_valid && !dec_ready`.
- **Reset mid-operation:** both entries are discarded immediately (asynchronous).
- **Flush with `dec_ready` low in TWO:** `dec_valid=0` and `EXE_ready=1` on the next cycle.

## Configuration
- `IDU_ILLEGAL_CHK_EN` defined:
  - Unknown opcodes, bad `funct3`/`funct7` on OP, and shift-immediate with `funct7 ∉ {0x00,0x20}` raise cause `10`.
  - FENCE and SYSTEM decode as legal no-ops, with all control bits 0.
- Not defined:
  - The illegal check logic is absent.
  - Cause `10` is never produced.
  - Unknown opcodes decode with all control bits 0 and `dec_exc` driven only by `addr_unaligned`.

## Structure
- **`idu_pkg`:**
  - Opcode constants: `LUI`, `AUIPC`, `JAL`, `JALR`, `BRANCH`, `LOAD`, `STORE`, `OP_IMM`, `OP`, `MISC_MEM`, `SYSTEM`.
  - ALU op encodings: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, PASSB=10.
  - `dec_ctrl` bit indices.
  - Cause codes.
- **`idu_decoder`:** one combinational sub-module for instruction→fields/imm/fn/ctrl/illegal. The `idu` top holds the skid FSM and registers.

## Test plan
1. **Reset:** assert `rst` → `dec_valid=0`, `EXE_ready=1`, `dec_imm=0`.
2. **ADDI:** `0x00500093` @ PC `0x80` with `dec_ready=1` → next cycle `dec_valid=1`, `dec_pc=0x80`, `rd=1`, `rs1=0`, `imm=5`, `fn=ADD`, `ctrl=0x81`.
3. **BEQ:** `0xFE208CE3` → `rs1=1`, `rs2=2`, `imm=0xFFFFFFF8`, `fn=SUB`, `ctrl=0x08`, `funct3=0`.
4. **Backpressure:** `dec_ready=0`, feed A, then B → `EXE_ready=0` the cycle after B is accepted, C is held. Raise `dec_ready` → A, B, C emerge in order with no loss or duplication.
5. **Flush in TWO:** pulse `INT_flush` with a beat offered → next cycle `dec_valid=0`, `EXE_ready=1`, and no stale beat is ever emitted.
6. **Faults:**
   - `0xFFFFFFFF` → `dec_exc=1`, `cause=10`, `ctrl=0` with `IDU_ILLEGAL_CHK_EN` defined; `dec_exc=0` without it.
   - `addr_unaligned=1` with illegal word → `cause=01`.
